descriptor_reader: RTL and testbench

- Reader side of the descriptor ROM. On a GET_DESCRIPTOR request it fetches bytes from the single-port ROM (10-bit address, 8-bit data, 1-cycle registered read latency).
- It streams the bytes to the USB IN packetiser in max-packet-sized chunks.
- Handles wLength truncation, host ACK/retry per packet, zero-length-packet (ZLP) termination, and abort on a new SETUP.

---
 rtl/usb_desc_pkg.sv | 28 ++
 rtl/descriptor_reader.sv | 148 ++++++++++++++
 tb/tb_descriptor_reader.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_desc_pkg.sv
// Shared descriptor-ROM definitions: reader FSM states, descriptor types and ROM layout.
package usb_desc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    HOLD,
    ZLP,
    WAIT_HS,
    DONE
  } state_t;

  localparam logic [7:0] DESC_TYPE_DEVICE        = 8'd1;
  localparam logic [7:0] DESC_TYPE_CONFIGURATION = 8'd2;

  localparam int DEVICE_DESC_BASE = 0;
  localparam int DEVICE_DESC_LEN  = 18;
  localparam int CONFIG_DESC_BASE = 18;
  localparam int CONFIG_DESC_LEN  = 16;

  localparam int DEFAULT_MAX_PKT = 8;

  function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/descriptor_reader.sv
// Streams a descriptor from a 1-cycle ROM in MAX_PKT chunks; 3 cycles/byte min (ADDR, DATA, HOLD).
// Byte held in HOLD until tx_ready; each packet waits for ack (advance) or retry (resend).
module descriptor_reader
  import usb_desc_pkg::*;
#(
  parameter int MAX_PKT = DEFAULT_MAX_PKT,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [15:0]       req_desc_len,
  input  logic [15:0]       req_wlength,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_last,
  output logic              tx_zlp,
  input  logic              tx_ready,
  input  logic              pkt_ack,
  input  logic              pkt_retry,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]       total_q, total_d;
  logic [15:0]       offset_q, offset_d;
  logic [15:0]       pkt_start_q, pkt_start_d;
  logic              zlp_needed_q, zlp_needed_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic [15:0]       req_total, pkt_len, pkt_end;
  logic [ADDR_W-1:0] addr_cur;
  logic              byte_last, was_zlp;

  always_comb begin
    req_total = min16(req_desc_len, req_wlength);
    pkt_len   = min16(16'(MAX_PKT), total_q - pkt_start_q);
    pkt_end   = pkt_start_q + pkt_len;
    byte_last = (offset_q - pkt_start_q) == (pkt_len - 16'd1);
    // A packet starting at the end of the data can only be the ZLP.
    was_zlp   = (pkt_start_q == total_q);
    addr_cur  = base_q + offset_q[ADDR_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    rom_addr_d   = rom_addr_q;
    total_d      = total_q;
    offset_d     = offset_q;
    pkt_start_d  = pkt_start_q;
    zlp_needed_d = zlp_needed_q;
    tx_data_d    = tx_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d       = req_base;
          total_d      = req_total;
          zlp_needed_d = (req_total != 16'd0) && (req_total < req_wlength) &&
                         ((req_total % 16'(MAX_PKT)) == 16'd0);
          offset_d     = 16'd0;
          pkt_start_d  = 16'd0;
          state_d      = (req_total == 16'd0) ? DONE : ADDR;
        end
      end
      ADDR: begin
        rom_addr_d = addr_cur;
        state_d    = DATA;
      end
      DATA: begin
        tx_data_d = rom_data;
        state_d   = HOLD;
      end
      HOLD: begin
        if (tx_ready) begin
          if (byte_last) begin
            state_d = WAIT_HS;
          end else begin
            offset_d = offset_q + 16'd1;
            state_d  = ADDR;
          end
        end
      end
      ZLP: begin
        if (tx_ready) state_d = WAIT_HS;
      end
      WAIT_HS: begin
        if (pkt_ack) begin
          pkt_start_d = pkt_end;
          offset_d    = pkt_end;
          if (was_zlp)                 state_d = DONE;
          else if (pkt_end == total_q) state_d = zlp_needed_q ? ZLP : DONE;
          else                         state_d = ADDR;
        end else if (pkt_retry) begin
          offset_d = pkt_start_q;
          state_d  = was_zlp ? ZLP : ADDR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      tx_data_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      rom_addr_q   <= '0;
      total_q      <= 16'd0;
      offset_q     <= 16'd0;
      pkt_start_q  <= 16'd0;
      zlp_needed_q <= 1'b0;
      tx_data_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      rom_addr_q   <= rom_addr_d;
      total_q      <= total_d;
      offset_q     <= offset_d;
      pkt_start_q  <= pkt_start_d;
      zlp_needed_q <= zlp_needed_d;
      tx_data_q    <= tx_data_d;
    end
  end

  // Address is presented combinationally in ADDR so the ROM returns data during DATA.
  assign rom_addr  = (state_q == ADDR) ? addr_cur : rom_addr_q;
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign tx_valid  = (state_q == HOLD);
  assign tx_data   = tx_data_q;
  assign tx_last   = ((state_q == HOLD) && byte_last) || (state_q == ZLP);
  assign tx_zlp    = (state_q == ZLP);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_descriptor_reader.sv
// Directed bench for descriptor_reader with a registered 1-cycle descriptor ROM as partner.
module tb_descriptor_reader;
  import usb_desc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_base = '0;
  logic [15:0] req_desc_len = '0;
  logic [15:0] req_wlength = '0;
  logic        abort = 1'b0;
  logic [9:0]  rom_addr;
  logic [7:0]  rom_data = '0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        tx_zlp;
  logic        tx_ready = 1'b0;
  logic        pkt_ack = 1'b0;
  logic        pkt_retry = 1'b0;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rom_mem [0:1023];
  logic [7:0] dev_bytes [0:17] = '{8'h12, 8'h01, 8'h10, 8'h01, 8'h02, 8'h00, 8'h00, 8'h08,
                                   8'h83, 8'h04, 8'h2A, 8'h57, 8'h00, 8'h01, 8'h00, 8'h00,
                                   8'h00, 8'h01};
  logic [7:0] cfg_bytes [0:15] = '{8'h09, 8'h02, 8'h10, 8'h00, 8'h01, 8'h01, 8'h00, 8'h80,
                                   8'h32, 8'h09, 8'h04, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};

  descriptor_reader #(.MAX_PKT(8), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base),
    .req_desc_len(req_desc_len), .req_wlength(req_wlength), .abort(abort),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_zlp(tx_zlp),
    .tx_ready(tx_ready), .pkt_ack(pkt_ack), .pkt_retry(pkt_retry),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input int base, input int dlen, input int wlen, input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_base     = 10'(base);
    req_desc_len = 16'(dlen);
    req_wlength  = 16'(wlen);
    req_valid    = 1'b1;
    tick();
    req_valid    = 1'b0;
  endtask

  // Accept one data packet with tx_ready high; checks every byte against the ROM image.
  task automatic get_pkt(input int base, input int first, input int n_exp, input string tag);
    int got = 0;
    int cyc = 0;
    tx_ready = 1'b1;
    while (got < n_exp && cyc < 100) begin
      tick();
      cyc++;
      if (tx_valid) begin
        chk({tag, " data"}, 32'(tx_data), 32'(rom_mem[10'((base + first + got) % 1024)]));
        chk({tag, " last"}, 32'(tx_last), 32'(got == n_exp - 1));
        got++;
      end
    end
    chk({tag, " count"}, 32'(got), 32'(n_exp));
    tick();
    chk({tag, " valid drop"}, 32'(tx_valid), 32'd0);
  endtask

  task automatic get_zlp(input string tag);
    int cyc = 0;
    tx_ready = 1'b1;
    while (!tx_zlp && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, " zlp"}, 32'(tx_zlp), 32'd1);
    chk({tag, " zlp last"}, 32'(tx_last), 32'd1);
    chk({tag, " zlp valid"}, 32'(tx_valid), 32'd0);
    tick();
    chk({tag, " zlp drop"}, 32'(tx_zlp), 32'd0);
  endtask

  task automatic ack_pkt();
    pkt_ack = 1'b1;
    tick();
    pkt_ack = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    chk({tag, " done"}, 32'(done), 32'd1);
    tick();
    chk({tag, " done once"}, 32'(done), 32'd0);
    chk({tag, " idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 8'h00;
    for (int i = 0; i < 18; i++) rom_mem[DEVICE_DESC_BASE + i] = dev_bytes[i];
    for (int i = 0; i < 16; i++) rom_mem[CONFIG_DESC_BASE + i] = cfg_bytes[i];
    rom_mem[1020] = 8'hA0;
    rom_mem[1021] = 8'hA1;
    rom_mem[1022] = 8'hA2;
    rom_mem[1023] = 8'hA3;

    // Reset values
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst tx_valid", 32'(tx_valid), 32'd0);
    chk("rst tx_last", 32'(tx_last), 32'd0);
    chk("rst tx_zlp", 32'(tx_zlp), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst rom_addr", 32'(rom_addr), 32'd0);
    chk("rst tx_data", 32'(tx_data), 32'd0);

    // Device descriptor, wLength 64: 8 + 8 + 2, no ZLP
    start(0, 18, 64, "t1");
    chk("t1 busy", 32'(busy), 32'd1);
    get_pkt(0, 0, 8, "t1p1");
    chk("t1p1 byte8", 32'(tx_data), 32'h08);
    ack_pkt();
    get_pkt(0, 8, 8, "t1p2");
    ack_pkt();
    get_pkt(0, 16, 2, "t1p3");
    ack_pkt();
    chk("t1 no zlp", 32'(tx_zlp), 32'd0);
    expect_done("t1");

    // wLength equals one packet: no ZLP
    start(0, 18, 8, "t2");
    get_pkt(0, 0, 8, "t2p1");
    ack_pkt();
    expect_done("t2");

    // Configuration, 16 bytes into wLength 255: ZLP terminates
    start(CONFIG_DESC_BASE, 16, 255, "t3");
    get_pkt(CONFIG_DESC_BASE, 0, 8, "t3p1");
    ack_pkt();
    get_pkt(CONFIG_DESC_BASE, 8, 8, "t3p2");
    ack_pkt();
    chk("t3 no early done", 32'(done), 32'd0);
    get_zlp("t3");
    chk("t3 wait busy", 32'(busy), 32'd1);
    ack_pkt();
    expect_done("t3");

    start(CONFIG_DESC_BASE, 16, 16, "t3b");
    get_pkt(CONFIG_DESC_BASE, 0, 8, "t3bp1");
    ack_pkt();
    get_pkt(CONFIG_DESC_BASE, 8, 8, "t3bp2");
    ack_pkt();
    expect_done("t3b");

    // Retry of packet 2 resends identical bytes; ack+retry together acts as ack
    start(0, 18, 64, "t4");
    get_pkt(0, 0, 8, "t4p1");
    ack_pkt();
    get_pkt(0, 8, 8, "t4p2");
    pkt_retry = 1'b1;
    tick();
    pkt_retry = 1'b0;
    chk("t4 retry no done", 32'(done), 32'd0);
    get_pkt(0, 8, 8, "t4p2r");
    chk("t4 resend last byte", 32'(tx_data), 32'h00);
    ack_pkt();
    get_pkt(0, 16, 2, "t4p3");
    chk("t4 tail byte", 32'(tx_data), 32'h01);
    pkt_ack = 1'b1;
    pkt_retry = 1'b1;
    tick();
    pkt_ack = 1'b0;
    pkt_retry = 1'b0;
    expect_done("t4");

    // Stall on byte 3, stray ack ignored, then abort
    start(0, 18, 64, "t5");
    tx_ready = 1'b1;
    cyc = 0;
    for (int n = 0; n < 2 && cyc < 50; ) begin
      tick();
      cyc++;
      if (tx_valid) n++;
    end
    tick();
    tx_ready = 1'b0;
    cyc = 0;
    while (!tx_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    pkt_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t5 stall valid", 32'(tx_valid), 32'd1);
      chk("t5 stall data", 32'(tx_data), 32'h10);
      chk("t5 stall last", 32'(tx_last), 32'd0);
      chk("t5 stall addr", 32'(rom_addr), 32'd2);
      tick();
      pkt_ack = 1'b0;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5 abort ready", 32'(req_ready), 32'd1);
    chk("t5 abort busy", 32'(busy), 32'd0);
    chk("t5 abort valid", 32'(tx_valid), 32'd0);
    chk("t5 abort last", 32'(tx_last), 32'd0);
    chk("t5 abort done", 32'(done), 32'd0);
    tick();
    chk("t5 abort no done", 32'(done), 32'd0);

    // abort beats a simultaneous request
    req_base = 10'd0;
    req_desc_len = 16'd18;
    req_wlength = 16'd64;
    req_valid = 1'b1;
    abort = 1'b1;
    tick();
    req_valid = 1'b0;
    abort = 1'b0;
    chk("t5b not accepted", 32'(busy), 32'd0);
    tick();
    chk("t5b still idle", 32'(tx_valid), 32'd0);

    // wLength 0: done right after accept, no bytes
    start(0, 18, 0, "t5c");
    chk("t5c no valid", 32'(tx_valid), 32'd0);
    expect_done("t5c");

    // Reset mid-packet
    start(0, 18, 64, "t6");
    tx_ready = 1'b1;
    cyc = 0;
    while (!tx_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6 rst ready", 32'(req_ready), 32'd1);
    chk("t6 rst busy", 32'(busy), 32'd0);
    chk("t6 rst valid", 32'(tx_valid), 32'd0);
    chk("t6 rst last", 32'(tx_last), 32'd0);
    chk("t6 rst zlp", 32'(tx_zlp), 32'd0);
    chk("t6 rst done", 32'(done), 32'd0);
    chk("t6 rst rom_addr", 32'(rom_addr), 32'd0);
    chk("t6 rst tx_data", 32'(tx_data), 32'd0);
    tick();
    chk("t6 rst no done", 32'(done), 32'd0);

    // Address wrap: 1020..1023, 0, 1
    start(1020, 6, 64, "t7");
    get_pkt(1020, 0, 6, "t7p1");
    chk("t7 wrapped byte", 32'(tx_data), 32'h01);
    ack_pkt();
    expect_done("t7");

    tx_ready = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
